// File: rtl/sprite_engine_multi_if.sv
// Register bus between the TinyQV core and the sprite peripheral.
// The core drives address, write data and strobes; the peripheral returns read data.
interface sprite_engine_multi_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready
  );
endinterface

// File: rtl/sprite_engine_multi.sv
// VGA raster and sprite renderer with double-buffered sprite registers.
// Optional macro SPRITE_COLLISION_EN adds a sprite-overlap flag and interrupt.
module sprite_engine_multi #(
  parameter int   NUM_SPRITES = 4,
  parameter int   SCALE_SHIFT = 2,
  parameter int   H_ACTIVE    = 1024,
  parameter int   H_FP        = 24,
  parameter int   H_SYNC      = 136,
  parameter int   H_BP        = 160,
  parameter int   V_ACTIVE    = 768,
  parameter int   V_FP        = 3,
  parameter int   V_SYNC      = 6,
  parameter int   V_BP        = 29,
  parameter logic SYNC_POL    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sprite_engine_multi_if.slave bus,
  output logic [7:0]           uo_out,
  output logic                 user_interrupt
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam int N  = NUM_SPRITES;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          en_q, irq_en_q, irq_q, coll;
  logic [7:0]    frame_q;
  logic [5:0]    bg_q;
  logic [3:0]    sel_q;

  logic [7:0]  sx_q [N];
  logic [7:0]  sx_d [N];
  logic [7:0]  sy_q [N];
  logic [7:0]  sy_d [N];
  logic [4:0]  sc_q [N];
  logic [4:0]  sc_d [N];
  logic [63:0] sb_q [N];
  logic [63:0] sb_d [N];
  logic [7:0]  ax_q [N];
  logic [7:0]  ay_q [N];
  logic [4:0]  ac_q [N];
  logic [63:0] ab_q [N];

  logic [N-1:0] hit_d, hit_q;
  logic         vis_d, vis_q, hs_d, hs_q, vs_d, vs_q;
  logic [5:0]   rgb;
  logic [7:0]   lx, ly;
  logic [31:0]  rdata;
  logic [31:0]  hx, vx;
  logic         wr, w16, w32, commit;

  assign wr  = bus.data_write_n != 2'b11;
  assign w16 = bus.data_write_n == 2'b01;
  assign w32 = bus.data_write_n == 2'b10;
  assign commit = en_q && h_q == '0 && v_q == VW'(V_ACTIVE);

  function automatic logic [5:0] pal(input logic [1:0] p);
    case (p)
      2'd0:    pal = 6'b111111;
      2'd1:    pal = 6'b110000;
      2'd2:    pal = 6'b001100;
      default: pal = 6'b000011;
    endcase
  endfunction

  // Raster counters; parked at the origin while the engine is disabled
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!en_q) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == HW'(HT - 1)) begin
      h_d = '0;
      v_d = (v_q == VW'(VT - 1)) ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  // Counter state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Shadow next-state from writes through the sprite window
  always_comb begin
    sx_d = sx_q;
    sy_d = sy_q;
    sc_d = sc_q;
    sb_d = sb_q;
    for (int i = 0; i < N; i++) begin
      if (wr && sel_q == 4'(i)) begin
        if (bus.address == 6'h04 && w16) begin
          sx_d[i] = bus.data_in[7:0];
          sy_d[i] = bus.data_in[15:8];
        end
        if (bus.address == 6'h06)
          sc_d[i] = bus.data_in[4:0];
        if (bus.address == 6'h08 && w32)
          sb_d[i][31:0] = bus.data_in;
        if (bus.address == 6'h0C && w32)
          sb_d[i][63:32] = bus.data_in;
      end
    end
  end

  // Shadow registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        sx_q[i] <= '0;
        sy_q[i] <= '0;
        sc_q[i] <= '0;
        sb_q[i] <= '0;
      end
    end else begin
      sx_q <= sx_d;
      sy_q <= sy_d;
      sc_q <= sc_d;
      sb_q <= sb_d;
    end
  end

  // Active copy: latched at vblank start, transparent while disabled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        ax_q[i] <= '0;
        ay_q[i] <= '0;
        ac_q[i] <= '0;
        ab_q[i] <= '0;
      end
    end else if (commit || !en_q) begin
      ax_q <= sx_d;
      ay_q <= sy_d;
      ac_q <= sc_d;
      ab_q <= sb_d;
    end
  end

  // Global registers, frame counter and vblank interrupt (set wins)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      frame_q  <= '0;
      bg_q     <= '0;
      sel_q    <= '0;
    end else begin
      if (wr && bus.address == 6'h00)
        {irq_en_q, en_q} <= bus.data_in[1:0];
      if (wr && bus.address == 6'h02)
        bg_q <= bus.data_in[5:0];
      if (wr && bus.address == 6'h03)
        sel_q <= bus.data_in[3:0];
      if (wr && bus.address == 6'h01 && bus.data_in[0])
        irq_q <= 1'b0;
      if (commit) begin
        frame_q <= frame_q + 1'b1;
        if (irq_en_q)
          irq_q <= 1'b1;
      end
    end
  end

  assign hx = 32'(h_q);
  assign vx = 32'(v_q);
  assign lx = 8'(h_q >> SCALE_SHIFT);
  assign ly = 8'(v_q >> SCALE_SHIFT);
  assign vis_d = en_q && hx < H_ACTIVE && vx < V_ACTIVE;
  assign hs_d = en_q && hx >= H_ACTIVE + H_FP
             && hx < H_ACTIVE + H_FP + H_SYNC;
  assign vs_d = en_q && vx >= V_ACTIVE + V_FP
             && vx < V_ACTIVE + V_FP + V_SYNC;

  for (genvar g = 0; g < N; g++) begin : g_spr
    logic [7:0] dx, dy;
    logic [2:0] col, row;
    assign dx  = lx - ax_q[g];
    assign dy  = ly - ay_q[g];
    assign col = ac_q[g][2] ? ~dx[2:0] : dx[2:0];
    assign row = ac_q[g][3] ? ~dy[2:0] : dy[2:0];
    assign hit_d[g] = ac_q[g][4] && dx[7:3] == '0
                   && dy[7:3] == '0 && ab_q[g][{row, col}];
  end

  // Stage 1: hit vector and timing flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q <= '0;
      vis_q <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
    end else begin
      hit_q <= hit_d;
      vis_q <= vis_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  // Stage 2 colour: highest-index hit wins, else background
  always_comb begin
    rgb = bg_q;
    for (int i = 0; i < N; i++)
      if (hit_q[i]) rgb = pal(ac_q[i][1:0]);
    if (!vis_q) rgb = '0;
  end

  // Stage 2 output register
  always_ff @(posedge clk) begin
    if (!rst_n)
      uo_out <= {~SYNC_POL, 3'b000, ~SYNC_POL, 3'b000};
    else
      uo_out <= {hs_q ? SYNC_POL : ~SYNC_POL,
                 rgb[0], rgb[2], rgb[4],
                 vs_q ? SYNC_POL : ~SYNC_POL,
                 rgb[1], rgb[3], rgb[5]};
  end

`ifdef SPRITE_COLLISION_EN
  logic coll_q;
  // Overlap flag: two or more hits on a visible pixel (set wins)
  always_ff @(posedge clk) begin
    if (!rst_n)
      coll_q <= 1'b0;
    else begin
      if (wr && bus.address == 6'h01 && bus.data_in[1])
        coll_q <= 1'b0;
      if (vis_q && |(hit_q & (hit_q - N'(1))))
        coll_q <= 1'b1;
    end
  end
  assign coll = coll_q;
  assign user_interrupt = irq_q | (irq_en_q & coll_q);
`else
  assign coll = 1'b0;
  assign user_interrupt = irq_q;
`endif

  // Readback of globals and the selected shadow
  always_comb begin
    rdata = '0;
    case (bus.address)
      6'h00: rdata = {30'd0, irq_en_q, en_q};
      6'h01: rdata = {16'd0, frame_q, 6'd0, coll, irq_q};
      6'h02: rdata = {26'd0, bg_q};
      6'h03: rdata = {28'd0, sel_q};
      6'h04, 6'h06, 6'h08, 6'h0C: begin
        for (int i = 0; i < N; i++) begin
          if (sel_q == 4'(i)) begin
            case (bus.address)
              6'h04:   rdata = {16'd0, sy_q[i], sx_q[i]};
              6'h06:   rdata = {27'd0, sc_q[i]};
              6'h08:   rdata = sb_q[i][31:0];
              default: rdata = sb_q[i][63:32];
            endcase
          end
        end
      end
      default: rdata = '0;
    endcase
  end

  assign bus.data_out   = (bus.data_read_n != 2'b11) ? rdata : '0;
  assign bus.data_ready = 1'b1;
endmodule

// File: tb/tb_sprite_engine_multi.sv
// Directed bench for sprite_engine_multi on a reduced raster.
// Pixel checks are scheduled from the cycle the engine was enabled.
module tb_sprite_engine_multi;
  localparam int HA = 80, HF = 2, HS = 4, HB = 2;
  localparam int VA = 56, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int NC = VA * HT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] uo;
  logic irq;
  int cyc = 0;
  int t0 = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sprite_engine_multi_if bus ();

  sprite_engine_multi #(
    .NUM_SPRITES(4), .SCALE_SHIFT(2),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .uo_out(uo),
    .user_interrupt(irq)
  );

  typedef struct {
    int         x;
    int         y;
    logic [7:0] e;
    string      nm;
  } px_t;

  px_t tab[15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    int tgt;
    int guard;
    tgt = t0 + n;
    while (tgt <= cyc) tgt += FT;
    guard = 0;
    while (cyc != tgt && guard < 2 * FT) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != tgt) chk("wait_timeout", 32'(cyc), 32'(tgt));
  endtask

  task automatic check_px(input int x, input int y,
                          input logic [7:0] e, input string nm);
    wait_cyc(y * HT + x + 2);
    chk(nm, 32'(uo), 32'(e));
  endtask

  task automatic bus_drive(input logic [5:0] a, input logic [31:0] d,
                           input logic [1:0] w);
    bus.address      = a;
    bus.data_in      = d;
    bus.data_write_n = w;
    @(posedge clk);
    #1 bus.data_write_n = 2'b11;
  endtask

  task automatic bus_wr(input logic [5:0] a, input logic [31:0] d,
                        input logic [1:0] w);
    @(negedge clk);
    bus_drive(a, d, w);
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] e,
                    input logic [31:0] m, input string nm);
    @(negedge clk);
    bus.address     = a;
    bus.data_read_n = 2'b00;
    #1 chk(nm, bus.data_out & m, e);
    bus.data_read_n = 2'b11;
  endtask

  task automatic rd_frames(input string nm);
    int n;
    int e;
    @(negedge clk);
    n = cyc - t0 - NC - 1;
    e = (n < 0) ? 0 : ((n / FT + 1) % 256);
    bus.address     = 6'h01;
    bus.data_read_n = 2'b00;
    #1 chk(nm, (bus.data_out >> 8) & 32'hFF, 32'(e));
    bus.data_read_n = 2'b11;
  endtask

  initial begin
    tab[0]  = '{0,  0,  8'h88, "bg_origin"};
    tab[1]  = '{81, 0,  8'h88, "hs_before"};
    tab[2]  = '{82, 0,  8'h08, "hs_first"};
    tab[3]  = '{85, 0,  8'h08, "hs_last"};
    tab[4]  = '{86, 0,  8'h88, "hs_after"};
    tab[5]  = '{40, 19, 8'h88, "spr_above"};
    tab[6]  = '{39, 20, 8'h88, "spr_left"};
    tab[7]  = '{40, 20, 8'h99, "spr_tl"};
    tab[8]  = '{43, 20, 8'h99, "spr_tr"};
    tab[9]  = '{44, 20, 8'h88, "spr_right"};
    tab[10] = '{43, 23, 8'h99, "spr_br"};
    tab[11] = '{40, 24, 8'h88, "spr_below"};
    tab[12] = '{10, 57, 8'h80, "vs_on"};
    tab[13] = '{82, 57, 8'h00, "vs_hs_on"};
    tab[14] = '{10, 59, 8'h88, "vs_off"};

    bus.address      = '0;
    bus.data_in      = '0;
    bus.data_write_n = 2'b11;
    bus.data_read_n  = 2'b11;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_uo", 32'(uo), 32'h88);
    chk("rst_irq", 32'(irq), 32'h0);
    rd(6'h00, 32'h0, 32'hFFFF_FFFF, "rst_ctrl");
    rd(6'h01, 32'h0, 32'hFFFF_FFFF, "rst_status");

    bus_wr(6'h03, 32'h0, 2'b00);
    bus_wr(6'h04, 32'h050A, 2'b01);
    bus_wr(6'h06, 32'h11, 2'b00);
    bus_wr(6'h08, 32'h1, 2'b10);
    bus_wr(6'h0C, 32'h0, 2'b10);
    bus_wr(6'h02, 32'h0, 2'b00);
    @(negedge clk);
    chk("idle_uo", 32'(uo), 32'h88);
    bus_wr(6'h00, 32'h1, 2'b00);
    t0 = cyc;

    for (int i = 0; i < 15; i++)
      check_px(tab[i].x, tab[i].y, tab[i].e, tab[i].nm);

    bus_wr(6'h06, 32'h15, 2'b00);
    wait_cyc(NC + 1);
    check_px(40, 20, 8'h88, "hflip_old");
    check_px(68, 20, 8'h99, "hflip_new");

    bus_wr(6'h06, 32'h1D, 2'b00);
    wait_cyc(NC + 1);
    check_px(68, 20, 8'h88, "vflip_old");
    check_px(68, 48, 8'h99, "vflip_new");

    bus_wr(6'h06, 32'h11, 2'b00);
    wait_cyc(NC + 1);
    wait_cyc(2 * HT);
    bus_wr(6'h04, 32'h050F, 2'b01);
    check_px(40, 20, 8'h99, "mid_old_pos");
    check_px(60, 20, 8'h88, "mid_new_dark");
    wait_cyc(NC + 1);
    check_px(40, 20, 8'h88, "mid_old_gone");
    check_px(60, 20, 8'h99, "mid_new_pos");
    rd_frames("frame_cnt_a");

    bus_wr(6'h04, 32'h050A, 2'b01);
    bus_wr(6'h06, 32'h10, 2'b00);
    bus_wr(6'h08, 32'h5, 2'b10);
    bus_wr(6'h03, 32'h2, 2'b00);
    bus_wr(6'h04, 32'h050A, 2'b01);
    bus_wr(6'h06, 32'h13, 2'b00);
    bus_wr(6'h08, 32'h3, 2'b10);
    bus_wr(6'h03, 32'h0, 2'b00);
    wait_cyc(NC + 1);
    check_px(40, 20, 8'hCC, "ovl_prio");
    check_px(44, 20, 8'hCC, "ovl_s2_only");
    check_px(48, 20, 8'hFF, "ovl_s0_white");
    check_px(52, 20, 8'h88, "ovl_none");
`ifdef SPRITE_COLLISION_EN
    rd(6'h01, 32'h2, 32'h2, "coll_set");
    bus_wr(6'h01, 32'h2, 2'b00);
    rd(6'h01, 32'h0, 32'h2, "coll_clr");
`else
    rd(6'h01, 32'h0, 32'h2, "coll_absent");
`endif

    bus_wr(6'h02, 32'h0C, 2'b00);
    check_px(0, 0, 8'hAA, "bg_green");
    check_px(85, 0, 8'h08, "bg_hblank");
    check_px(20, 10, 8'hAA, "bg_mid");
    check_px(0, 56, 8'h88, "bg_vblank");

    bus_wr(6'h03, 32'h5, 2'b00);
    rd(6'h04, 32'h0, 32'hFFFF_FFFF, "sel_oob_rd");
    bus_wr(6'h04, 32'h0707, 2'b01);
    bus_wr(6'h03, 32'h0, 2'b00);
    rd(6'h04, 32'h050A, 32'hFFFF_FFFF, "sel_oob_wr");
    bus_wr(6'h04, 32'h0303, 2'b10);
    rd(6'h04, 32'h050A, 32'hFFFF_FFFF, "xy_width");
    bus_wr(6'h08, 32'hFF, 2'b00);
    rd(6'h08, 32'h5, 32'hFFFF_FFFF, "bm_width");
    rd(6'h06, 32'h10, 32'hFFFF_FFFF, "ctrl_rd");
    rd(6'h3F, 32'h0, 32'hFFFF_FFFF, "unmapped");
    rd(6'h02, 32'h0C, 32'hFFFF_FFFF, "bg_rd");

    bus_wr(6'h03, 32'h2, 2'b00);
    bus_wr(6'h06, 32'h0, 2'b00);
    bus_wr(6'h03, 32'h0, 2'b00);
    wait_cyc(NC + 1);
    bus_wr(6'h01, 32'h3, 2'b00);
    bus_wr(6'h00, 32'h3, 2'b00);
    rd_frames("frame_cnt_b");
    wait_cyc(NC);
    chk("irq_pre", 32'(irq), 32'h0);
    @(negedge clk);
    chk("irq_set", 32'(irq), 32'h1);
    rd(6'h01, 32'h1, 32'h1, "irq_status");
    bus_wr(6'h01, 32'h1, 2'b00);
    @(negedge clk);
    chk("irq_clr", 32'(irq), 32'h0);
    wait_cyc(NC);
    bus_drive(6'h01, 32'h1, 2'b00);
    chk("irq_set_wins", 32'(irq), 32'h1);
    bus_wr(6'h00, 32'h1, 2'b00);
    @(negedge clk);
    chk("irq_en_off_hold", 32'(irq), 32'h1);
    bus_wr(6'h01, 32'h1, 2'b00);
    @(negedge clk);
    chk("irq_clr2", 32'(irq), 32'h0);

    check_px(30, 20, 8'hAA, "pre_reset_px");
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_uo", 32'(uo), 32'h88);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    rd(6'h00, 32'h0, 32'hFFFF_FFFF, "mid_rst_ctrl");
    rd(6'h01, 32'h0, 32'hFFFF_FFFF, "mid_rst_status");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("post_rst_uo", 32'(uo), 32'h88);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
